vector_dot_accumulator: RTL and testbench

VECTOR_DOT_ACCUMULATOR -- requirements
Module: vector_dot_accumulator

---
 rtl/vector_dot_accumulator_pkg.sv | 15 +
 rtl/dot_lane_sum.sv | 63 ++++++
 rtl/vector_dot_accumulator.sv | 132 +++++++++++++
 tb/tb_vector_dot_accumulator.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_dot_accumulator_pkg.sv
// Shared types and constants for the vector dot-product accumulator.
package vector_dot_accumulator_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        DONE
    } state_t;

    localparam int DRAIN_CYCLES = 3;
    localparam int ACC_GUARD    = 16;

endpackage

// File: rtl/dot_lane_sum.sv
// Per-lane signed multipliers followed by a registered adder tree:
// products land one edge after load, their sum one edge later.
module dot_lane_sum
    import vector_dot_accumulator_pkg::*;
#(
    parameter int no_of_units   = 8,
    parameter int element_width = 64
) (
    input  logic                                                       clk,
    input  logic                                                       reset,
    input  logic                                                       load,
    input  logic        [no_of_units*element_width-1:0]                vec_a,
    input  logic        [no_of_units*element_width-1:0]                vec_b,
    output logic signed [2*element_width+$clog2(no_of_units)-1:0]      lane_sum,
    output logic                                                       sum_valid
);

    localparam int prod_width = 2 * element_width;
    localparam int sum_width  = prod_width + $clog2(no_of_units);

    logic signed [prod_width-1:0] prod [no_of_units];
    logic signed [sum_width-1:0]  tree_sum;
    logic                         prod_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the product array is reset element by element because an
            // aborted pass must leave no stale partial products behind.
            for (int i = 0; i < no_of_units; i++) prod[i] <= '0;
            prod_valid <= 1'b0;
        end else begin
            prod_valid <= load;
            if (load) begin
                for (int i = 0; i < no_of_units; i++) begin
                    prod[i] <= prod_width'($signed(vec_a[i*element_width +: element_width]))
                             * prod_width'($signed(vec_b[i*element_width +: element_width]));
                end
            end
        end
    end

    // NOTE: tree_sum is given a default before the loop so no path through
    // this block leaves it unassigned (no latch).
    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < no_of_units; i++) begin
            tree_sum = tree_sum + sum_width'(prod[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_sum  <= '0;
            sum_valid <= 1'b0;
        end else begin
            lane_sum  <= tree_sum;
            sum_valid <= prod_valid;
        end
    end

endmodule

// File: rtl/vector_dot_accumulator.sv
// Fixed-point dot product over a row-streamed vector pair.
// Define DOT_SATURATE_EN to saturate dot_result and drive the sticky overflow flag.
module vector_dot_accumulator
    import vector_dot_accumulator_pkg::*;
#(
    parameter int no_of_units   = 8,
    parameter int element_width = 64,
    parameter int frac_bits     = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [31:0]                          total,
    input  logic                                 row_valid,
    input  logic [no_of_units*element_width-1:0] vec_a,
    input  logic [no_of_units*element_width-1:0] vec_b,
    output logic                                 read_again,
    output logic                                 busy,
    output logic [element_width-1:0]             dot_result,
    output logic                                 vXv1_finish,
    output logic                                 overflow
);

    localparam int sum_width = 2 * element_width + $clog2(no_of_units);
    localparam int acc_width = sum_width + ACC_GUARD;
    localparam int drain_w   = $clog2(DRAIN_CYCLES);

    state_t                        state, next_state;
    logic [31:0]                   rows, rows_in, row_count;
    logic [drain_w-1:0]            drain_count;
    logic signed [acc_width-1:0]   acc;
    logic signed [sum_width-1:0]   lane_sum;
    logic                          sum_valid;
    logic [element_width-1:0]      result_next;

    assign rows_in = total / 32'(no_of_units);

    dot_lane_sum #(
        .no_of_units   (no_of_units),
        .element_width (element_width)
    ) u_lane_sum (
        .clk       (clk),
        .reset     (reset),
        .load      (state == WAIT && row_valid),
        .vec_a     (vec_a),
        .vec_b     (vec_b),
        .lane_sum  (lane_sum),
        .sum_valid (sum_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        read_again = (state == REQ);
        busy       = (state != IDLE);
        case (state)
            IDLE:  if (start) next_state = (rows_in == 32'd0) ? DONE : REQ;
            REQ:   next_state = WAIT;
            WAIT:  if (row_valid) next_state = (row_count == rows - 32'd1) ? DRAIN : REQ;
            DRAIN: if (drain_count == drain_w'(DRAIN_CYCLES - 1)) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows        <= '0;
            row_count   <= '0;
            drain_count <= '0;
            acc         <= '0;
            dot_result  <= '0;
            vXv1_finish <= 1'b0;
        end else begin
            vXv1_finish <= 1'b0;
            drain_count <= '0;
            if (sum_valid) acc <= acc + acc_width'(lane_sum);
            case (state)
                IDLE: if (start) begin
                    rows      <= rows_in;
                    row_count <= '0;
                    acc       <= '0;
                end
                WAIT:  if (row_valid) row_count <= row_count + 32'd1;
                DRAIN: drain_count <= drain_count + drain_w'(1);
                DONE: begin
                    dot_result  <= result_next;
                    vXv1_finish <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef DOT_SATURATE_EN
    localparam logic signed [acc_width-1:0] sat_max =
        {{(acc_width - element_width + 1){1'b0}}, {(element_width - 1){1'b1}}};
    localparam logic signed [acc_width-1:0] sat_min = ~sat_max;

    logic signed [acc_width-1:0] shifted;
    logic                        saturate;

    always_comb begin
        shifted     = acc >>> frac_bits;
        saturate    = 1'b0;
        result_next = shifted[element_width-1:0];
        if (shifted > sat_max) begin
            result_next = {1'b0, {(element_width - 1){1'b1}}};
            saturate    = 1'b1;
        end else if (shifted < sat_min) begin
            result_next = {1'b1, {(element_width - 1){1'b0}}};
            saturate    = 1'b1;
        end
    end

    // Sticky until the next accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                       overflow <= 1'b0;
        else if (state == IDLE && start)  overflow <= 1'b0;
        else if (state == DONE && saturate) overflow <= 1'b1;
    end
`else
    // Low element_width bits of acc >>> frac_bits.
    assign result_next = acc[frac_bits +: element_width];
    assign overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_vector_dot_accumulator.sv
// Scoreboard bench: directed scenarios plus random passes against a plain-arithmetic model.
module tb_vector_dot_accumulator;

    localparam int NU = 8;
    localparam int EW = 64;

    typedef struct {
        logic [63:0] res;
        bit          ovf;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              start;
    logic [31:0]       total;
    logic              row_valid;
    logic [NU*EW-1:0]  vec_a;
    logic [NU*EW-1:0]  vec_b;
    logic              read_again;
    logic              busy;
    logic [EW-1:0]     dot_result;
    logic              vXv1_finish;
    logic              overflow;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    exp_t        exp_q[$];
    logic [NU*EW-1:0] qa[$];
    logic [NU*EW-1:0] qb[$];
    logic [63:0] last_exp = '0;

    vector_dot_accumulator dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .total       (total),
        .row_valid   (row_valid),
        .vec_a       (vec_a),
        .vec_b       (vec_b),
        .read_again  (read_again),
        .busy        (busy),
        .dot_result  (dot_result),
        .vXv1_finish (vXv1_finish),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, req);
        end
    endtask

    // Reference: sum of element products, shifted by 32 fraction bits, then wrap or clamp.
    function automatic void model(input int tot, output logic [63:0] res, output bit ovf);
        logic signed [146:0] acc, pa, pb, sh;
        logic signed [146:0] smax, smin;
        logic signed [63:0]  ea, eb;
        logic [NU*EW-1:0]    ra, rb;
        smax = 147'sh7FFF_FFFF_FFFF_FFFF;
        smin = -smax - 147'sd1;
        acc  = '0;
        for (int r = 0; r < tot / NU; r++) begin
            ra = qa[r];
            rb = qb[r];
            for (int l = 0; l < NU; l++) begin
                ea  = ra[l*EW +: EW];
                eb  = rb[l*EW +: EW];
                pa  = ea;
                pb  = eb;
                acc = acc + pa * pb;
            end
        end
        sh  = acc >>> 32;
        res = sh[63:0];
        ovf = 1'b0;
`ifdef DOT_SATURATE_EN
        if (sh > smax) begin
            res = 64'h7FFF_FFFF_FFFF_FFFF;
            ovf = 1'b1;
        end else if (sh < smin) begin
            res = 64'h8000_0000_0000_0000;
            ovf = 1'b1;
        end
`else
        if (smin > smax) ovf = 1'b1;
`endif
    endfunction

    task automatic fill_const(input int nrows, input logic [63:0] a, input logic [63:0] b);
        qa.delete();
        qb.delete();
        for (int r = 0; r < nrows; r++) begin
            qa.push_back({NU{a}});
            qb.push_back({NU{b}});
        end
    endtask

    task automatic fill_random(input int nrows);
        logic [NU*EW-1:0]   ra, rb;
        logic signed [63:0] e;
        qa.delete();
        qb.delete();
        for (int r = 0; r < nrows; r++) begin
            for (int l = 0; l < NU; l++) begin
                e = {$urandom(), $urandom()};
                ra[l*EW +: EW] = e >>> $urandom_range(40, 0);
                e = {$urandom(), $urandom()};
                rb[l*EW +: EW] = e >>> $urandom_range(40, 0);
            end
            qa.push_back(ra);
            qb.push_back(rb);
        end
    endtask

    task automatic run_pass(input int tot, input int gap_max, input bit misbehave,
                            input bit use_exp, input logic [63:0] exp_res, input bit exp_ovf);
        exp_t e;
        int nrows, ra_cnt, ri, pend, start_cyc, last_acc, fin_cyc;
        nrows = tot / NU;
        if (use_exp) begin
            e.res = exp_res;
            e.ovf = exp_ovf;
        end else begin
            model(tot, e.res, e.ovf);
        end
        exp_q.push_back(e);
        @(negedge clk);
        start     = 1'b1;
        total     = tot;
        start_cyc = cyc;
        ra_cnt = 0; ri = 0; pend = 0; last_acc = -100; fin_cyc = -1;
        for (int t = 0; t < 200 + nrows * 10 && fin_cyc < 0; t++) begin
            @(negedge clk);
            start     = 1'b0;
            row_valid = 1'b0;
            if (t == 0) begin
                check("busy_after_start", busy, 1);
                check("result_held", dot_result, last_exp);
                check("overflow_cleared_on_start", overflow, 0);
            end
            if (vXv1_finish) fin_cyc = cyc;
            if (pend > 0) begin
                pend--;
                if (pend == 0 && ri < qa.size()) begin
                    vec_a     = qa[ri];
                    vec_b     = qb[ri];
                    row_valid = 1'b1;
                    last_acc  = cyc;
                    ri++;
                    if (misbehave) begin
                        start = 1'b1;
                        total = 32'd5;
                    end
                end
            end
            if (read_again) begin
                ra_cnt++;
                pend = 1 + $urandom_range(gap_max, 0);
                if (misbehave) begin
                    row_valid = 1'b1;
                    vec_a     = {NU{64'h5555_0000_1234_0000}};
                    vec_b     = {NU{64'h0000_0007_0000_0000}};
                end
            end
        end
        if (fin_cyc < 0)     check("finish_timeout", 0, 1);
        else if (nrows > 0)  check("finish_after_last_row", fin_cyc - last_acc, 5);
        else                 check("finish_after_start", fin_cyc - start_cyc, 2);
        check("read_again_count", ra_cnt, nrows);
        check("busy_at_finish", busy, 0);
        @(negedge clk);
        start     = 1'b0;
        row_valid = 1'b0;
        check("finish_single_pulse", vXv1_finish, 0);
        last_exp = e.res;
    endtask

    // Monitor: every completion pulse consumes one expected response.
    always @(negedge clk) begin
        exp_t e;
        if (vXv1_finish) begin
            check("finish_vs_read_again", read_again, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_finish", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("dot_result", dot_result, e.res);
                check("overflow", overflow, e.ovf);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of run, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ra_cnt, pend, tot;
        reset = 1'b0; start = 1'b0; total = '0; row_valid = 1'b0;
        vec_a = '0; vec_b = '0;
        repeat (2) @(negedge clk);
        check("reset_read_again", read_again, 0);
        check("reset_busy", busy, 0);
        check("reset_dot_result", dot_result, 0);
        check("reset_finish", vXv1_finish, 0);
        check("reset_overflow", overflow, 0);
        reset = 1'b1;

        // 2 rows of 1.0 * 2.0 -> 32.0
        fill_const(2, 64'h1_0000_0000, 64'h2_0000_0000);
        run_pass(16, 0, 1'b0, 1'b1, 64'h20_0000_0000, 1'b0);

        // mixed signs: 4 * (3.0 * -1.0) + 4 * (-2.0 * -2.0) -> 4.0
        qa.delete(); qb.delete();
        qa.push_back({{4{64'hFFFF_FFFE_0000_0000}}, {4{64'h3_0000_0000}}});
        qb.push_back({{4{64'hFFFF_FFFE_0000_0000}}, {4{64'hFFFF_FFFF_0000_0000}}});
        run_pass(8, 0, 1'b0, 1'b1, 64'h4_0000_0000, 1'b0);

        // fewer elements than one row
        run_pass(5, 0, 1'b0, 1'b1, 64'h0, 1'b0);

        // stray start in WAIT and stray row_valid in REQ
        fill_const(2, 64'h1_0000_0000, 64'h2_0000_0000);
        run_pass(16, 0, 1'b1, 1'b1, 64'h20_0000_0000, 1'b0);

        // reset during the second WAIT
        @(negedge clk);
        start = 1'b1; total = 32'd16; ra_cnt = 0; pend = 0;
        for (int t = 0; t < 50 && ra_cnt < 2; t++) begin
            @(negedge clk);
            start = 1'b0; row_valid = 1'b0;
            if (pend > 0) begin
                vec_a = qa[0]; vec_b = qb[0]; row_valid = 1'b1; pend = 0;
            end
            if (read_again) begin
                ra_cnt++;
                pend = 1;
            end
        end
        check("abort_read_again_count", ra_cnt, 2);
        @(negedge clk);
        row_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_read_again", read_again, 0);
        check("abort_busy", busy, 0);
        check("abort_dot_result", dot_result, 0);
        check("abort_finish", vXv1_finish, 0);
        check("abort_overflow", overflow, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        last_exp = '0;
        run_pass(16, 0, 1'b0, 1'b1, 64'h20_0000_0000, 1'b0);

        // largest positive operands
        fill_const(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
`ifdef DOT_SATURATE_EN
        run_pass(8, 0, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
`else
        run_pass(8, 0, 1'b0, 1'b1, 64'hFFFF_FFF8_0000_0000, 1'b0);
`endif

        for (int p = 0; p < 20; p++) begin
            tot = $urandom_range(40, 0);
            fill_random(tot / NU);
            run_pass(tot, 2, 1'b0, 1'b0, 64'h0, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
